// File: rtl/pcpu_defs.sv
// rtl/pcpu_defs.sv - shared pipeline definitions: hazard FSM encodings and multicycle latency default
package pcpu_defs;

    localparam int MD_LAT_DEFAULT = 8;
    localparam int MD_CNT_W       = 5;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_MD_DONE = 2'd2
    } hz_state_t;

    // A load into r0 never creates a dependency, since r0 is hardwired to zero.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rt_ex,
        input logic [4:0] rs_id,
        input logic [4:0] rt_id
    );
        return mem_read && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear priority
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use, multicycle mul/div stall, branch flush
module hazard_ctrl
    import pcpu_defs::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead_ex_i,
    input  logic [4:0]       rt_ex_i,
    input  logic [4:0]       rs_id_i,
    input  logic [4:0]       rt_id_i,
    input  logic             branch_taken_id_i,
    input  logic             md_start_ex_i,
    input  logic             cnt_clr_i,
    output logic             PC_IFWrite_o,
    output logic             IF_flush_o,
    output logic             ID_EX_write_o,
    output logic             ID_EX_flush_o,
    output logic             EX_MEM_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // The first stall cycle is spent in RUN, so the wait state covers the remaining MD_LAT-1.
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

    hz_state_t           state, state_nx;
    logic [MD_CNT_W-1:0] md_cnt, md_cnt_nx;
    logic                load_use;
    logic                resolve;

    assign load_use = load_use_hit(MemRead_ex_i, rt_ex_i, rs_id_i, rt_id_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nx;
            md_cnt <= md_cnt_nx;
        end
    end

    always_comb begin
        PC_IFWrite_o   = 1'b1;
        IF_flush_o     = 1'b0;
        ID_EX_write_o  = 1'b1;
        ID_EX_flush_o  = 1'b0;
        EX_MEM_flush_o = 1'b0;
        state_nx       = state;
        md_cnt_nx      = md_cnt;
        resolve        = 1'b0;

        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (md_start_ex_i) begin
                        PC_IFWrite_o   = 1'b0;
                        ID_EX_write_o  = 1'b0;
                        EX_MEM_flush_o = 1'b1;
                        md_cnt_nx      = MD_LOAD;
                        state_nx       = ST_MD_WAIT;
                    end else begin
                        resolve = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    PC_IFWrite_o   = 1'b0;
                    ID_EX_write_o  = 1'b0;
                    EX_MEM_flush_o = 1'b1;
                    md_cnt_nx      = md_cnt - 1'b1;
                    if (md_cnt <= MD_CNT_W'(1)) begin
                        state_nx = ST_MD_DONE;
                    end
                end
                ST_MD_DONE: begin
                    // The finished op may still assert md_start for this cycle; it must not restart.
                    resolve  = 1'b1;
                    state_nx = ST_RUN;
                end
                default: begin
                    state_nx = ST_RUN;
                end
            endcase

            if (resolve) begin
                if (load_use) begin
                    PC_IFWrite_o  = 1'b0;
                    ID_EX_flush_o = 1'b1;
                end else if (branch_taken_id_i) begin
                    IF_flush_o = 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .inc   (!PC_IFWrite_o && !rst),
        .clr   (rst || cnt_clr_i),
        .count (stall_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_read, br, md, clr;
    logic [4:0]  rt_ex, rs_id, rt_id;
    logic        pc_w, if_fl, idex_w, idex_fl, exmem_fl;
    logic [15:0] scnt;

    logic        rst4, mem_read4, br4, md4, clr4;
    logic [4:0]  rt_ex4, rs_id4, rt_id4;
    logic        pc_w4, if_fl4, idex_w4, idex_fl4, exmem_fl4;
    logic [3:0]  scnt4;

    int passed = 0;
    int total  = 0;

    hazard_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .MemRead_ex_i      (mem_read),
        .rt_ex_i           (rt_ex),
        .rs_id_i           (rs_id),
        .rt_id_i           (rt_id),
        .branch_taken_id_i (br),
        .md_start_ex_i     (md),
        .cnt_clr_i         (clr),
        .PC_IFWrite_o      (pc_w),
        .IF_flush_o        (if_fl),
        .ID_EX_write_o     (idex_w),
        .ID_EX_flush_o     (idex_fl),
        .EX_MEM_flush_o    (exmem_fl),
        .stall_cnt_o       (scnt)
    );

    hazard_ctrl #(
        .MD_LAT (2),
        .CNT_W  (4)
    ) dut4 (
        .clk               (clk),
        .rst               (rst4),
        .MemRead_ex_i      (mem_read4),
        .rt_ex_i           (rt_ex4),
        .rs_id_i           (rs_id4),
        .rt_id_i           (rt_id4),
        .branch_taken_id_i (br4),
        .md_start_ex_i     (md4),
        .cnt_clr_i         (clr4),
        .PC_IFWrite_o      (pc_w4),
        .IF_flush_o        (if_fl4),
        .ID_EX_write_o     (idex_w4),
        .ID_EX_flush_o     (idex_fl4),
        .EX_MEM_flush_o    (exmem_fl4),
        .stall_cnt_o       (scnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_read = 1'b0; rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
        br = 1'b0; md = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; idle();
        rst4 = 1'b1; mem_read4 = 1'b0; rt_ex4 = 5'd0; rs_id4 = 5'd0; rt_id4 = 5'd0;
        br4 = 1'b0; md4 = 1'b0; clr4 = 1'b0;
        tick(); tick();

        // held in reset: hazard inputs must be ignored
        mem_read = 1'b1; rt_ex = 5'd5; rs_id = 5'd5; #1;
        chk("rst_pcw", pc_w, 1);
        chk("rst_idexfl", idex_fl, 0);
        tick();
        chk("rst_cnt", scnt, 0);

        // load-use on rs
        rst = 1'b0; #1;
        chk("lu_pcw", pc_w, 0);
        chk("lu_idexfl", idex_fl, 1);
        chk("lu_idexw", idex_w, 1);
        chk("lu_iffl", if_fl, 0);
        chk("lu_exmem", exmem_fl, 0);
        tick(); idle(); #1;
        chk("lu_cnt", scnt, 1);
        chk("lu_release", pc_w, 1);

        // load into r0 never stalls
        mem_read = 1'b1; rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0; #1;
        chk("r0_pcw", pc_w, 1);
        chk("r0_idexfl", idex_fl, 0);
        tick();

        // load-use on rt
        mem_read = 1'b1; rt_ex = 5'd7; rs_id = 5'd3; rt_id = 5'd7; #1;
        chk("rt_pcw", pc_w, 0);
        tick();
        mem_read = 1'b0; rt_ex = 5'd7; rs_id = 5'd7; #1;
        chk("noload_pcw", pc_w, 1);
        chk("rt_cnt", scnt, 2);

        // load-use beats branch, then branch alone flushes
        tick();
        mem_read = 1'b1; rt_ex = 5'd9; rs_id = 5'd9; rt_id = 5'd0; br = 1'b1; #1;
        chk("prio_iffl", if_fl, 0);
        chk("prio_pcw", pc_w, 0);
        tick();
        mem_read = 1'b0; #1;
        chk("br_iffl", if_fl, 1);
        chk("br_pcw", pc_w, 1);
        chk("br_idexfl", idex_fl, 0);
        chk("br_cnt", scnt, 3);

        // counter clear
        tick(); idle(); clr = 1'b1; #1;
        tick(); clr = 1'b0; #1;
        chk("clr_cnt", scnt, 0);

        // multicycle op, MD_LAT = 8
        md = 1'b1; #1;
        for (int i = 0; i < 8; i++) begin
            chk("md_pcw", pc_w, 0);
            chk("md_exmem", exmem_fl, 1);
            chk("md_idexw", idex_w, 0);
            tick();
        end
        chk("mddone_pcw", pc_w, 1);
        chk("mddone_exmem", exmem_fl, 0);
        chk("mddone_cnt", scnt, 8);
        tick(); md = 1'b0; #1;
        chk("mdrun_pcw", pc_w, 1);
        chk("mdrun_cnt", scnt, 8);

        // md beats load-use and branch; then reset in third wait cycle
        tick();
        md = 1'b1; br = 1'b1; mem_read = 1'b1; rt_ex = 5'd4; rs_id = 5'd4; #1;
        chk("mdprio_pcw", pc_w, 0);
        chk("mdprio_iffl", if_fl, 0);
        chk("mdprio_idexfl", idex_fl, 0);
        chk("mdprio_exmem", exmem_fl, 1);
        tick(); br = 1'b0; mem_read = 1'b0; #1;
        tick(); tick();
        chk("wait3_pcw", pc_w, 0);
        rst = 1'b1; #1;
        chk("rstmd_pcw", pc_w, 1);
        chk("rstmd_exmem", exmem_fl, 0);
        tick(); rst = 1'b0; md = 1'b0; #1;
        chk("postrst_pcw", pc_w, 1);
        chk("postrst_exmem", exmem_fl, 0);
        chk("postrst_cnt", scnt, 0);

        // second instance: MD_LAT = 2, CNT_W = 4
        tick(); rst4 = 1'b0; md4 = 1'b1; #1;
        chk("md2_c1", pc_w4, 0);
        tick();
        chk("md2_c2", pc_w4, 0);
        tick();
        chk("md2_done", pc_w4, 1);
        chk("md2_cnt", scnt4, 2);
        tick(); md4 = 1'b0; mem_read4 = 1'b1; rt_ex4 = 5'd3; rt_id4 = 5'd3; #1;
        repeat (20) tick();
        chk("sat_cnt", scnt4, 15);
        chk("sat_pcw", pc_w4, 0);
        clr4 = 1'b1;
        tick(); clr4 = 1'b0; #1;
        chk("clr_stall_cnt", scnt4, 0);
        tick();
        chk("after_clr_cnt", scnt4, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter MD_LAT, default 8, total stall cycles for a multicycle multiply/divide op (legal range 2..32).
REQ-002 SHALL provide parameter CNT_W, default 16, width of the stall-cycle performance counter.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous active-high reset, sampled on posedge clk.
REQ-005 MemRead_ex_i  in  1  instruction in EX is a load.
REQ-006 rt_ex_i  in  5  load destination register in EX.
REQ-007 rs_id_i, rt_id_i  in  5 each  source registers of the instruction in ID.
REQ-008 branch_taken_id_i  in  1  branch/jump resolved taken in ID this cycle.
REQ-009 md_start_ex_i  in  1  multicycle mul/div op present in EX (level, held while the op sits in EX).
REQ-010 cnt_clr_i  in  1  synchronous clear of stall counter.
REQ-011 PC_IFWrite_o  out  1  PC and IF/ID write enable (0 = hold).
REQ-012 IF_flush_o  out  1  zero IF/ID on next write.
REQ-013 ID_EX_write_o  out  1  ID/EX write enable (0 = hold).
REQ-014 ID_EX_flush_o  out  1  load bubble (zeros) into ID/EX.
REQ-015 EX_MEM_flush_o  out  1  load bubble into EX/MEM.
REQ-016 stall_cnt_o  out  CNT_W  saturating count of cycles with PC_IFWrite_o=0.

Function
REQ-017 FSM states: RUN, MD_WAIT, MD_DONE; 5-bit down-counter md_cnt.
REQ-018 load_use = MemRead_ex_i & (rt_ex_i != 0) & (rt_ex_i == rs_id_i | rt_ex_i == rt_id_i).
REQ-019 RUN, md_start_ex_i=1: PC_IFWrite_o=0, ID_EX_write_o=0, EX_MEM_flush_o=1, ID_EX_flush_o=0, IF_flush_o=0; md_cnt <= MD_LAT-1; next MD_WAIT.
REQ-020 MD_WAIT: same outputs as REQ-019; md_cnt decrements each cycle; when md_cnt==1 next MD_DONE; md_start_ex_i ignored.
REQ-021 Net effect: md op first seen in cycle N stalls cycles N..N+MD_LAT-1 (exactly MD_LAT cycles); pipeline advances in cycle N+MD_LAT.
REQ-022 MD_DONE (one cycle): md_start_ex_i ignored, load_use/branch evaluated as in RUN; next RUN unconditionally.
REQ-023 RUN/MD_DONE without md start, load_use=1: PC_IFWrite_o=0, ID_EX_write_o=1, ID_EX_flush_o=1, IF_flush_o=0, EX_MEM_flush_o=0; state unchanged.
REQ-024 RUN/MD_DONE, no stall, branch_taken_id_i=1: IF_flush_o=1, all writes enabled, other flushes 0.
REQ-025 Priority: md stall > load_use > branch flush; IF_flush_o SHALL never be 1 while PC_IFWrite_o=0.
REQ-026 Idle default: PC_IFWrite_o=1, ID_EX_write_o=1, all flushes 0.
REQ-027 Outputs combinational from state and current inputs (same-cycle response); state/counters registered.
REQ-028 stall_cnt_o increments on every cycle with PC_IFWrite_o=0, saturates at all-ones; cnt_clr_i has priority over increment (clears to 0).

Reset
REQ-029 rst=1 at posedge: state <= RUN, md_cnt <= 0, stall_cnt_o <= 0.
REQ-030 While rst=1, outputs SHALL be idle default (REQ-026) regardless of inputs; the counter does not increment.
REQ-031 rst asserted mid MD_WAIT aborts the stall; first cycle after reset is RUN.

Structure
REQ-032 State encodings and MD_LAT default SHALL live in the shared pcpu_defs header used by the pipeline registers.
REQ-033 Saturating counter SHALL be a sub-module sat_counter (parameter width, inc, clr).
REQ-034 Target 120-250 lines RTL; no latches, one always block for state, one for outputs.

Verification
REQ-035 Load rt_ex=5, rs_id=5 for 1 cycle -> PC_IFWrite=0, ID_EX_flush=1 that cycle, stall_cnt=1.
REQ-036 Load rt_ex=0, rs_id=0 -> no stall (PC_IFWrite=1, ID_EX_flush=0).
REQ-037 md_start held 8 cycles, MD_LAT=8 -> exactly 8 stall cycles, MD_DONE on 9th with PC_IFWrite=1 despite md_start=1, stall_cnt=8.
REQ-038 branch_taken_id=1 with load_use=1 -> IF_flush=0, PC_IFWrite=0; next cycle branch only -> IF_flush=1.
REQ-039 rst at 3rd MD_WAIT cycle -> next cycle RUN, outputs idle, stall_cnt=0.
REQ-040 CNT_W=4, 20 stall cycles -> stall_cnt holds 15; cnt_clr together with stall -> 0.
